// File: rtl/tumble_counter.sv
// tumble_counter
//   Clocked Turing Tumble engine. Blue and red marble reservoirs feed a chain
//   of NBITS flip-bits that behave as a ripple counter. Every marble is
//   recorded in an ordered tray. A start pulse runs the machine until the
//   next lever's reservoir is empty or the counter overflows.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   DROP  | take one marble of the current colour from its reservoir
//   ROLL  | marble visits bits[idx]; one cycle per bit touched
//   LAND  | marble enters the tray; choose the next lever or stop
//   STOP  | run finished, outputs frozen until the next start
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           run request, honoured only in IDLE and STOP
//   mode            0 = COUNT (always blue lever), 1 = ALTERNATE colours
//   stopped, busy   registered status flags
//   tray, tray_size landed marble colours (bit i = i-th marble, 1 = red), count
//   bits            flip-bit states, bit 0 first in the chain
//   blue_left,
//   red_left        marbles remaining in each reservoir
module tumble_counter #(
  parameter int NBITS      = 4,
  parameter int NUM_BLUE   = 8,
  parameter int NUM_RED    = 8,
  parameter int TRAY_DEPTH = 20,
  parameter int TSW        = $clog2(TRAY_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  output logic                  stopped,
  output logic                  busy,
  output logic [TRAY_DEPTH-1:0] tray,
  output logic [TSW-1:0]        tray_size,
  output logic [NBITS-1:0]      bits,
  output logic [TSW-1:0]        blue_left,
  output logic [TSW-1:0]        red_left
);

  localparam int              IW        = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [IW-1:0]   LAST      = IW'(NBITS - 1);
  localparam logic [TSW-1:0]  BLUE_INIT = TSW'(NUM_BLUE);
  localparam logic [TSW-1:0]  RED_INIT  = TSW'(NUM_RED);

  if (TRAY_DEPTH < NUM_BLUE + NUM_RED) begin : g_bad_tray
    $error("tumble_counter: TRAY_DEPTH must be >= NUM_BLUE + NUM_RED");
  end
  if (NBITS < 1 || NBITS > 16) begin : g_bad_nbits
    $error("tumble_counter: NBITS must be in 1..16");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DROP = 3'd1,
    S_ROLL = 3'd2,
    S_LAND = 3'd3,
    S_STOP = 3'd4
  } state_t;

  state_t state, state_nx;

  logic          colour, colour_nx;     // colour of the marble in flight
  logic          mode_run, mode_run_nx; // mode latched on accepted start
  logic          overflow, overflow_nx;
  logic [IW-1:0] idx, idx_nx;

  logic                  stopped_nx, busy_nx;
  logic [TRAY_DEPTH-1:0] tray_nx;
  logic [TSW-1:0]        tray_size_nx, blue_left_nx, red_left_nx;
  logic [NBITS-1:0]      bits_nx;

  // A start from STOP reloads the reservoirs on the same edge, so the
  // blue-availability test must look at the reload value there.
  logic [TSW-1:0] blue_at_start;
  logic           start_ok;
  logic           next_colour;
  logic           next_avail;

  assign blue_at_start = (state == S_STOP) ? BLUE_INIT : blue_left;
  assign start_ok      = (blue_at_start != '0);
  assign next_colour   = mode_run ? ~colour : 1'b0;
  assign next_avail    = next_colour ? (red_left != '0) : (blue_left != '0);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_STOP: if (start) state_nx = start_ok ? S_DROP : S_STOP;
      S_DROP:         state_nx = S_ROLL;
      S_ROLL:         if (!bits[idx] || idx == LAST) state_nx = S_LAND;
      S_LAND: begin
        if (overflow)        state_nx = S_STOP;
        else if (next_avail) state_nx = S_DROP;
        else                 state_nx = S_STOP;
      end
      default:        state_nx = S_IDLE;
    endcase
  end

  // output / datapath next values
  always_comb begin
    colour_nx    = colour;
    mode_run_nx  = mode_run;
    overflow_nx  = overflow;
    idx_nx       = idx;
    tray_nx      = tray;
    tray_size_nx = tray_size;
    bits_nx      = bits;
    blue_left_nx = blue_left;
    red_left_nx  = red_left;
    // status flags trail the state by one edge
    stopped_nx   = (state == S_STOP);
    busy_nx      = (state == S_DROP) || (state == S_ROLL) || (state == S_LAND);

    case (state)
      S_IDLE, S_STOP: begin
        if (start) begin
          mode_run_nx = mode;
          colour_nx   = 1'b0;
          if (state == S_STOP) begin
            tray_nx      = '0;
            tray_size_nx = '0;
            bits_nx      = '0;
            blue_left_nx = BLUE_INIT;
            red_left_nx  = RED_INIT;
          end
        end
      end
      S_DROP: begin
        if (colour) red_left_nx  = red_left - TSW'(1);
        else        blue_left_nx = blue_left - TSW'(1);
        idx_nx      = '0;
        overflow_nx = 1'b0;
      end
      S_ROLL: begin
        bits_nx[idx] = ~bits[idx];
        if (bits[idx]) begin
          if (idx == LAST) overflow_nx = 1'b1;
          else             idx_nx      = idx + IW'(1);
        end
      end
      S_LAND: begin
        // tray_size never reaches TRAY_DEPTH here, so exactly one slot matches
        for (int k = 0; k < TRAY_DEPTH; k++) begin
          if (tray_size == TSW'(k)) tray_nx[k] = colour;
        end
        tray_size_nx = tray_size + TSW'(1);
        colour_nx    = next_colour;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour    <= 1'b0;
      mode_run  <= 1'b0;
      overflow  <= 1'b0;
      idx       <= '0;
      stopped   <= 1'b0;
      busy      <= 1'b0;
      tray      <= '0;
      tray_size <= '0;
      bits      <= '0;
      blue_left <= BLUE_INIT;
      red_left  <= RED_INIT;
    end else begin
      colour    <= colour_nx;
      mode_run  <= mode_run_nx;
      overflow  <= overflow_nx;
      idx       <= idx_nx;
      stopped   <= stopped_nx;
      busy      <= busy_nx;
      tray      <= tray_nx;
      tray_size <= tray_size_nx;
      bits      <= bits_nx;
      blue_left <= blue_left_nx;
      red_left  <= red_left_nx;
    end
  end

endmodule

// File: tb/tb_tumble_counter.sv
// tb_tumble_counter
//   Self-checking bench for tumble_counter. Several instances with different
//   parameters share one clock and reset; each puzzle drives its own start
//   and mode inputs.
module tb_tumble_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // a: latency, NBITS=3, one blue marble
  logic a_start, a_mode, a_stopped, a_busy;
  logic [19:0] a_tray; logic [4:0] a_size, a_blue, a_red; logic [2:0] a_bits;
  tumble_counter #(.NBITS(3), .NUM_BLUE(1), .NUM_RED(8), .TRAY_DEPTH(20)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode),
    .stopped(a_stopped), .busy(a_busy), .tray(a_tray), .tray_size(a_size),
    .bits(a_bits), .blue_left(a_blue), .red_left(a_red));

  // b: COUNT overflow, NBITS=3, ten blue marbles
  logic b_start, b_mode, b_stopped, b_busy;
  logic [19:0] b_tray; logic [4:0] b_size, b_blue, b_red; logic [2:0] b_bits;
  tumble_counter #(.NBITS(3), .NUM_BLUE(10), .NUM_RED(8), .TRAY_DEPTH(20)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode),
    .stopped(b_stopped), .busy(b_busy), .tray(b_tray), .tray_size(b_size),
    .bits(b_bits), .blue_left(b_blue), .red_left(b_red));

  // c: ALTERNATE, NBITS=3, 3 blue + 2 red, tray exactly full
  logic c_start, c_mode, c_stopped, c_busy;
  logic [4:0] c_tray; logic [2:0] c_size, c_blue, c_red; logic [2:0] c_bits;
  tumble_counter #(.NBITS(3), .NUM_BLUE(3), .NUM_RED(2), .TRAY_DEPTH(5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .mode(c_mode),
    .stopped(c_stopped), .busy(c_busy), .tray(c_tray), .tray_size(c_size),
    .bits(c_bits), .blue_left(c_blue), .red_left(c_red));

  // d: empty blue reservoir
  logic d_start, d_mode, d_stopped, d_busy;
  logic [19:0] d_tray; logic [4:0] d_size, d_blue, d_red; logic [3:0] d_bits;
  tumble_counter #(.NBITS(4), .NUM_BLUE(0), .NUM_RED(8), .TRAY_DEPTH(20)) u_d (
    .clk(clk), .rst_n(rst_n), .start(d_start), .mode(d_mode),
    .stopped(d_stopped), .busy(d_busy), .tray(d_tray), .tray_size(d_size),
    .bits(d_bits), .blue_left(d_blue), .red_left(d_red));

  // e: default parameters, used for the mid-run reset
  logic e_start, e_mode, e_stopped, e_busy;
  logic [19:0] e_tray; logic [4:0] e_size, e_blue, e_red; logic [3:0] e_bits;
  tumble_counter u_e (
    .clk(clk), .rst_n(rst_n), .start(e_start), .mode(e_mode),
    .stopped(e_stopped), .busy(e_busy), .tray(e_tray), .tray_size(e_size),
    .bits(e_bits), .blue_left(e_blue), .red_left(e_red));

  typedef struct {
    logic start;
    int   stopped;
    int   busy;
    int   size;
    int   bits;
    int   blue;
  } vec_t;

  vec_t lat_tab[6];

  initial begin
    int cnt;

    // per-edge trace for u_a: start sampled at edge E (row 0)
    lat_tab[0] = '{1'b1, 0, 0, 0, 0, 1};
    lat_tab[1] = '{1'b0, 0, 1, 0, 0, 0}; // E+1 DROP
    lat_tab[2] = '{1'b0, 0, 1, 0, 1, 0}; // E+2 ROLL flips bit 0
    lat_tab[3] = '{1'b0, 0, 1, 1, 1, 0}; // E+3 LAND
    lat_tab[4] = '{1'b0, 1, 0, 1, 1, 0}; // E+4 stopped
    lat_tab[5] = '{1'b0, 1, 0, 1, 1, 0};

    rst_n = 1'b0;
    {a_start, b_start, c_start, d_start, e_start} = '0;
    {a_mode, b_mode, c_mode, d_mode, e_mode} = '0;
    #12;
    chk("rst_a_stopped", a_stopped, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_blue", a_blue, 1);
    chk("rst_a_red", a_red, 8);
    chk("rst_a_size", a_size, 0);
    rst_n = 1'b1;
    tick;

    // empty blue reservoir
    d_start = 1'b1;
    tick;
    d_start = 1'b0;
    chk("empty_stopped_E", d_stopped, 0);
    tick;
    chk("empty_stopped_E1", d_stopped, 1);
    chk("empty_busy", d_busy, 0);
    chk("empty_size", d_size, 0);
    chk("empty_bits", d_bits, 0);
    chk("empty_red", d_red, 8);

    // latency trace
    for (int r = 0; r < 6; r++) begin
      a_start = lat_tab[r].start;
      tick;
      chk($sformatf("lat%0d_stopped", r), a_stopped, lat_tab[r].stopped);
      chk($sformatf("lat%0d_busy", r), a_busy, lat_tab[r].busy);
      chk($sformatf("lat%0d_size", r), a_size, lat_tab[r].size);
      chk($sformatf("lat%0d_bits", r), a_bits, lat_tab[r].bits);
      chk($sformatf("lat%0d_blue", r), a_blue, lat_tab[r].blue);
    end
    chk("lat_tray", a_tray, 0);

    // COUNT overflow: 8 marbles, 30 busy edges, stopped on the 32nd edge
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    cnt = 1;
    while (!b_stopped && cnt < 200) begin tick; cnt++; end
    chk("ovf_edges", cnt, 32);
    chk("ovf_stopped", b_stopped, 1);
    chk("ovf_size", b_size, 8);
    chk("ovf_tray", b_tray, 0);
    chk("ovf_bits", b_bits, 0);
    chk("ovf_blue", b_blue, 2);
    chk("ovf_red", b_red, 8);

    // ALTERNATE run 1: B,R,B,R,B with k = 1,2,1,3,1 -> 18 busy edges
    c_mode  = 1'b1;
    c_start = 1'b1;
    tick;
    c_start = 1'b0;
    cnt = 1;
    while (!c_stopped && cnt < 200) begin tick; cnt++; end
    chk("alt1_edges", cnt, 20);
    chk("alt1_tray", c_tray, 5'b01010);
    chk("alt1_size", c_size, 5);
    chk("alt1_bits", c_bits, 3'b101);
    chk("alt1_blue", c_blue, 0);
    chk("alt1_red", c_red, 0);
    chk("alt1_busy", c_busy, 0);

    // ALTERNATE run 2 from STOP, start held into busy, mode toggled (ignored)
    c_start = 1'b1;
    tick;
    c_mode = 1'b0;
    chk("alt2_tray_clr", c_tray, 0);
    chk("alt2_size_clr", c_size, 0);
    chk("alt2_blue_reload", c_blue, 3);
    chk("alt2_red_reload", c_red, 2);
    chk("alt2_stopped_hold", c_stopped, 1);
    tick;
    chk("alt2_stopped_fall", c_stopped, 0);
    chk("alt2_busy", c_busy, 1);
    chk("alt2_blue_drop", c_blue, 2);
    cnt = 2;
    repeat (3) begin tick; cnt++; end
    c_start = 1'b0;
    while (!c_stopped && cnt < 200) begin tick; cnt++; end
    chk("alt2_edges", cnt, 20);
    chk("alt2_tray", c_tray, 5'b01010);
    chk("alt2_size", c_size, 5);
    chk("alt2_bits", c_bits, 3'b101);
    chk("alt2_red", c_red, 0);

    // mid-run asynchronous reset
    e_start = 1'b1;
    tick;
    e_start = 1'b0;
    repeat (10) tick;
    chk("rst_midrun_busy", e_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stopped", e_stopped, 0);
    chk("rst_mid_busy", e_busy, 0);
    chk("rst_mid_tray", e_tray, 0);
    chk("rst_mid_size", e_size, 0);
    chk("rst_mid_bits", e_bits, 0);
    chk("rst_mid_blue", e_blue, 8);
    chk("rst_mid_red", e_red, 8);
    #2;
    rst_n = 1'b1;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tumble_counter.md
# tumble_counter

Parametrised, clocked Turing Tumble puzzle engine: blue and red marble reservoirs feed a chain of NBITS flip-bits wired as a ripple counter, and each marble lands in an ordered tray. A start pulse runs the machine until a lever has no marble left or the counter overflows, then `stopped` asserts. It generalises the fixed single-puzzle blocks to any counter width, reservoir depth and tray depth, with a selectable lever-routing mode. Puzzle testbenches instantiate it directly.

## Interface
- NBITS, 4: number of flip-bits in the counter chain (1..16).
- NUM_BLUE, 8: initial blue reservoir count.
- NUM_RED, 8: initial red reservoir count.
- TRAY_DEPTH, 20: tray capacity; must be ≥ NUM_BLUE+NUM_RED (elaboration error otherwise).
- TSW, $clog2(TRAY_DEPTH+1): width of counts (derived, 5 by default).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE and STOP.
- mode  in  1  0 = COUNT, 1 = ALTERNATE; latched on accepted start.
- stopped  out  1  high in STOP state.
- busy  out  1  high in DROP/ROLL/LAND.
- tray  out  TRAY_DEPTH  bit i = colour of i-th landed marble (0 blue, 1 red).
- tray_size  out  TSW  marbles landed.
- bits  out  NBITS  flip-bit states, bit 0 first in chain.
- blue_left, red_left  out  TSW  marbles remaining per reservoir.

## Operation
- States: IDLE, DROP, ROLL, LAND, STOP. All outputs registered.
- IDLE: start=1 → if blue_left>0, DROP with colour blue; else STOP.
- DROP (1 cycle): decrement chosen reservoir; marble index i:=0; → ROLL.
- ROLL (1 cycle per bit visited): flip bits[i]. Old bit 0 → exit "settle" → LAND. Old bit 1 and i<NBITS-1 → i+1, stay ROLL. Old bit 1 and i=NBITS-1 → exit "overflow" → LAND.
- LAND (1 cycle): tray[tray_size]:=colour, tray_size+1. Then:
  - overflow → STOP (no lever).
  - COUNT: next colour blue. ALTERNATE: next colour = opposite of current.
  - next reservoir non-zero → DROP with that colour; else → STOP.
- STOP: holds all outputs. start=1 → clear tray, tray_size, bits; reload reservoirs; latch mode; proceed exactly as start from IDLE on the same edge.
- start in DROP/ROLL/LAND ignored. mode changes ignored except on accepted start.
- Reservoir decrement never underflows (checked before DROP). Tray never overflows by parameter rule.

## Timing
- Reset (async, immediate): state IDLE, stopped=0, busy=0, tray=0, tray_size=0, bits=0, blue_left=NUM_BLUE, red_left=NUM_RED, latched mode=0.
- start sampled high at edge E → DROP at E+1, first ROLL at E+2.
- Per marble: 1 DROP + k ROLL + 1 LAND, k = bits visited (1..NBITS).
- tray/tray_size update at the LAND edge; next DROP immediately follows.
- stopped rises the edge after the final LAND (or E+1 when blue reservoir empty); busy falls the same edge.
- Reset mid-run aborts immediately; marble in flight is lost, no partial tray write.

## Test plan
- Reset: rst_n low mid-run → all outputs at reset values, blue_left=8, red_left=8, stopped=0, without clock edge.
- Latency, NBITS=3, NUM_BLUE=1, bits=000: start at E → DROP E+1, ROLL E+2, LAND E+3 (tray_size=1, bits=001), stopped=1 at E+4.
- COUNT overflow, NBITS=3, NUM_BLUE=10: 8 marbles land, 8th overflows → stopped=1, tray_size=8, tray[7:0]=0, bits=000, blue_left=2.
- ALTERNATE, NBITS=3, NUM_BLUE=3, NUM_RED=2: landing order B,R,B,R,B → tray[4:0]=5'b01010, tray_size=5, bits=101, blue_left=0, red_left=0, stopped=1.
- start held/pulsed during busy → no change to sequence; start in STOP → tray=0, tray_size=0, reservoirs reloaded, stopped falls next edge, run repeats identically.
- Empty blue reservoir (NUM_BLUE=0): start → stopped=1 one edge later, tray_size=0, bits=0.
